// File: rtl/sdr_pkg.sv
// Shared definitions for the SDR serializer and the downstream shift-register bench.
package sdr_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    localparam int SDR_WIDTH = 4;

endpackage

// File: rtl/bit_counter.sv
// Bit-position counter: counts 0..WIDTH-1 and wraps, with synchronous clear and terminal count.
module bit_counter
    import sdr_pkg::*;
#(
    parameter int WIDTH = SDR_WIDTH
) (
    input  logic                     clk,
    input  logic                     clr,
    input  logic                     en,
    output logic [$clog2(WIDTH)-1:0] cnt,
    output logic                     tc
);

    localparam int            CW   = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    assign tc = (cnt == LAST);

    // WIDTH need not be a power of two, so wrap explicitly at LAST.
    always_ff @(posedge clk) begin
        if (clr)
            cnt <= '0;
        else if (en)
            cnt <= tc ? '0 : cnt + 1'b1;
    end

endmodule

// File: rtl/sdr_serializer.sv
// Parallel-to-serial converter, LSB first, with valid/ready load, stall and back-to-back words.
module sdr_serializer
    import sdr_pkg::*;
#(
    parameter int WIDTH = SDR_WIDTH
) (
    input  logic             clk,
    input  logic             clr,
    input  logic [WIDTH-1:0] din,
    input  logic             load_valid,
    output logic             load_ready,
    input  logic             shift_en,
    output logic             sdr,
    output logic             sdr_valid,
    output logic             done
);

    localparam int CW = $clog2(WIDTH);

    state_t           state, state_n;
    logic [WIDTH-1:0] shreg, shreg_n;
    logic             sdr_n, sdr_valid_n, done_n;
    logic [CW-1:0]    cnt;
    logic             tc, advance, wrap, accept;

    assign advance    = (state == SHIFT) && shift_en;
    assign wrap       = advance && tc;
    assign load_ready = (state == IDLE) || wrap;
    assign accept     = load_valid && load_ready;

    bit_counter #(.WIDTH(WIDTH)) u_cnt (
        .clk (clk),
        .clr (clr || accept || wrap),
        .en  (advance && !tc),
        .cnt (cnt),
        .tc  (tc)
    );

    always_ff @(posedge clk) begin
        if (clr) begin
            state     <= IDLE;
            shreg     <= '0;
            sdr       <= 1'b0;
            sdr_valid <= 1'b0;
            done      <= 1'b0;
        end else begin
            state     <= state_n;
            shreg     <= shreg_n;
            sdr       <= sdr_n;
            sdr_valid <= sdr_valid_n;
            done      <= done_n;
        end
    end

    // shreg holds the not-yet-presented bits with the current bit at [0].
    always_comb begin
        state_n     = state;
        shreg_n     = shreg;
        sdr_n       = sdr;
        sdr_valid_n = sdr_valid;
        done_n      = 1'b0;
        if (accept) begin
            state_n     = SHIFT;
            shreg_n     = din;
            sdr_n       = din[0];
            sdr_valid_n = 1'b1;
        end else if (wrap) begin
            state_n     = IDLE;
            shreg_n     = '0;
            sdr_n       = 1'b0;
            sdr_valid_n = 1'b0;
        end else if (advance) begin
            shreg_n = shreg >> 1;
            sdr_n   = shreg[1];
            done_n  = (cnt == CW'(WIDTH - 2));
        end
    end

endmodule

// File: tb/tb_sdr_serializer.sv
// Directed bench for sdr_serializer at WIDTH=4 and WIDTH=8 with a downstream right-shift model.
module tb_sdr_serializer;

    logic       clk = 1'b0;
    logic       clr, se, lv, lv8;
    logic [3:0] din;
    logic [7:0] din8;
    logic       rdy, sdr, vld, done;
    logic       rdy8, sdr8, vld8, done8;
    logic [3:0] q4;
    logic [7:0] q8;
    int         checks   = 0;
    int         failures = 0;

    always #5 clk = ~clk;

    sdr_serializer #(.WIDTH(4)) u_dut4 (
        .clk        (clk),
        .clr        (clr),
        .din        (din),
        .load_valid (lv),
        .load_ready (rdy),
        .shift_en   (se),
        .sdr        (sdr),
        .sdr_valid  (vld),
        .done       (done)
    );

    sdr_serializer #(.WIDTH(8)) u_dut8 (
        .clk        (clk),
        .clr        (clr),
        .din        (din8),
        .load_valid (lv8),
        .load_ready (rdy8),
        .shift_en   (se),
        .sdr        (sdr8),
        .sdr_valid  (vld8),
        .done       (done8)
    );

    // Downstream right-shift registers: SDR enters at the MSB on each advancing edge.
    always @(posedge clk) begin
        if (vld && se)  q4 <= {sdr, q4[3:1]};
        if (vld8 && se) q8 <= {sdr8, q8[7:1]};
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic one_word(input logic [3:0] w);
        din = w; lv = 1'b1; se = 1'b1;
        step();
        lv = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (i > 0) step();
            chk("w_sdr",  sdr,  w[i]);
            chk("w_vld",  vld,  1'b1);
            chk("w_done", done, i == 3);
            chk("w_rdy",  rdy,  i == 3);
        end
        step();
        chk("w_idle_vld", vld,  1'b0);
        chk("w_idle_sdr", sdr,  1'b0);
        chk("w_idle_rdy", rdy,  1'b1);
        chk("w_q",        q4,   w);
    endtask

    // Second word is presented (load_valid held) while the first is still shifting.
    task automatic b2b(input logic [3:0] a, input logic [3:0] b);
        logic [7:0] exp;
        exp = {b, a};
        din = a; lv = 1'b1; se = 1'b1;
        step();
        din = b;
        for (int i = 0; i < 8; i++) begin
            if (i > 0) step();
            if (i == 4) lv = 1'b0;
            chk("b_sdr",  sdr,  exp[i]);
            chk("b_vld",  vld,  1'b1);
            chk("b_done", done, (i == 3) || (i == 7));
            chk("b_rdy",  rdy,  (i == 3) || (i == 7));
        end
        step();
        chk("b_idle_vld", vld, 1'b0);
        chk("b_q",        q4,  b);
    endtask

    initial begin
        clr = 1'b1; se = 1'b0; lv = 1'b0; lv8 = 1'b0; din = '0; din8 = '0;
        step();
        step();
        chk("rst_sdr",  sdr,  1'b0);
        chk("rst_vld",  vld,  1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_rdy",  rdy,  1'b1);
        chk("rst_vld8", vld8, 1'b0);
        clr = 1'b0;
        step();
        chk("rst_rdy_after", rdy, 1'b1);

        one_word(4'b1011);
        b2b(4'b0110, 4'b1001);
        b2b(4'b0011, 4'b1100);

        // Load with shift_en low, then stall mid-word and on the last bit.
        din = 4'b1100; lv = 1'b1; se = 1'b0;
        step();
        chk("s_b0", sdr, 1'b0);
        chk("s_v0", vld, 1'b1);
        lv = 1'b0; se = 1'b1;
        step();
        chk("s_b1", sdr, 1'b0);
        se = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("s_hold_sdr",  sdr,  1'b0);
            chk("s_hold_vld",  vld,  1'b1);
            chk("s_hold_done", done, 1'b0);
            chk("s_hold_rdy",  rdy,  1'b0);
        end
        se = 1'b1;
        step();
        chk("s_b2",   sdr,  1'b1);
        chk("s_d2",   done, 1'b0);
        step();
        chk("s_b3",   sdr,  1'b1);
        chk("s_d3",   done, 1'b1);
        se = 1'b0;
        step();
        chk("s_last_sdr",  sdr,  1'b1);
        chk("s_last_done", done, 1'b0);
        chk("s_last_vld",  vld,  1'b1);
        se = 1'b1;
        step();
        chk("s_idle_vld", vld, 1'b0);
        chk("s_q",        q4,  4'b1100);

        // Abort mid-word; clear also wins over a simultaneous load.
        din = 4'b1111; lv = 1'b1; se = 1'b1;
        step();
        lv = 1'b0;
        step();
        chk("r_b1", sdr, 1'b1);
        clr = 1'b1; lv = 1'b1;
        step();
        chk("r_sdr",  sdr,  1'b0);
        chk("r_vld",  vld,  1'b0);
        chk("r_done", done, 1'b0);
        chk("r_rdy",  rdy,  1'b1);
        clr = 1'b0; lv = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("r_idle_vld",  vld,  1'b0);
            chk("r_idle_done", done, 1'b0);
        end

        // WIDTH=8 instance.
        din8 = 8'hA5; lv8 = 1'b1; se = 1'b1;
        step();
        lv8 = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (i > 0) step();
            chk("w8_sdr",  sdr8,  din8[i]);
            chk("w8_vld",  vld8,  1'b1);
            chk("w8_done", done8, i == 7);
        end
        step();
        chk("w8_idle_vld", vld8, 1'b0);
        chk("w8_q",        q8,   8'hA5);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
